// File: rtl/rowbias_server_if.sv
// Row-bias request interface between a tile (master) and the row-bias server (slave).
// Carries the one-hot lookup request, the reshuffle/seed strobes and the server response.
interface rowbias_server_if #(
    parameter int LEN = 9
);
    logic [LEN:0]   rqindex;
    logic           updaterowbias;
    logic           seed_load;
    logic [15:0]    seed;
    logic [LEN-1:0] rowbias;
    logic           busy;

    modport master (
        output rqindex, updaterowbias, seed_load, seed,
        input  rowbias, busy
    );

    modport slave (
        input  rqindex, updaterowbias, seed_load, seed,
        output rowbias, busy
    );
endinterface

// File: rtl/rowbias_server.sv
// Row-bias server: holds a permutation of one-hot row values, answers one-hot lookups a cycle
// later, and reshuffles in place (Fisher-Yates with a 16-bit Galois LFSR) on request.
module rowbias_server #(
    parameter int          LEN       = 9,
    parameter int          IW        = $clog2(LEN),
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input logic           clock,
    input logic           reset,
    rowbias_server_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHUF, DONE} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [LEN-1:0] perm_q [LEN];
    logic [LEN-1:0] perm_d [LEN];
    logic [LEN-1:0] rowbias_q, rowbias_d;
    logic           busy_q, busy_d;

    logic [15:0]    lfsr_step;
    logic [IW-1:0]  j;
    logic           accept;
    logic           hit;
    logic [LEN-1:0] sel;

    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign j         = lfsr_q[IW-1:0];
    assign accept    = (j <= i_q);

    // A request is valid only when exactly one bit below the sentinel is set, so an OR-mux suffices.
    always_comb begin
        hit = $onehot(bus.rqindex) && !bus.rqindex[LEN];
        sel = '0;
        for (int k = 0; k < LEN; k++) begin
            if (bus.rqindex[k]) sel = sel | perm_q[k];
        end
    end

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        lfsr_d    = lfsr_q;
        perm_d    = perm_q;
        rowbias_d = '0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                rowbias_d = hit ? sel : '0;
                if (bus.updaterowbias) begin
                    state_d = SHUF;
                    i_d     = IW'(LEN - 1);
                    busy_d  = 1'b1;
                end
            end
            SHUF: begin
                lfsr_d = lfsr_step;
                if (accept) begin
                    perm_d[i_q] = perm_q[j];
                    perm_d[j]   = perm_q[i_q];
                    i_d         = i_q - IW'(1);
                    if (i_q == IW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A zero seed would lock the LFSR, so it is dropped.
        if (bus.seed_load && (bus.seed != 16'h0000)) lfsr_d = bus.seed;
    end

    // NOTE: the permutation store is reset to identity because lookups right after reset rely on it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            lfsr_q    <= LFSR_INIT;
            rowbias_q <= '0;
            busy_q    <= 1'b0;
            for (int k = 0; k < LEN; k++) begin
                perm_q[k] <= {{(LEN-1){1'b0}}, 1'b1} << k;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            i_q       <= i_d;
            lfsr_q    <= lfsr_d;
            rowbias_q <= rowbias_d;
            busy_q    <= busy_d;
            perm_q    <= perm_d;
        end
    end

    assign bus.rowbias = rowbias_q;
    assign bus.busy    = busy_q;
endmodule

// File: doc/rowbias_server.md
Name: rowbias_server

Overview:
- Responder side of the tile's row-bias request interface.
- Holds one permutation of the GRID_LEN one-hot candidate values for a grid row.
- Returns the entry selected by a tile's one-hot rqindex, one cycle later.
- On updaterowbias, reshuffles the permutation in place (Fisher-Yates driven by a 16-bit LFSR), so backtracked rows try values in a new order.

Parameters:
- LEN, 9 (GRID_LEN): number of permutation entries; width of rowbias.
- IW, $clog2(LEN): width of the internal index counters.
- LFSR_INIT, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rqindex  in  LEN+1  one-hot request from tile; bit LEN is the "exhausted" sentinel.
- updaterowbias  in  1  single-cycle strobe; starts a reshuffle.
- seed_load  in  1  strobe; load seed into the LFSR.
- seed  in  16  LFSR seed; sampled when seed_load=1.
- rowbias  out  LEN  registered one-hot value for the requested index; 0 if none.
- busy  out  1  high while a reshuffle is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - perm[k] = 1<<k (identity), lfsr = LFSR_INIT, rowbias = 0, busy = 0, state IDLE.
  - Applies from any state, including mid-shuffle.
- LFSR: Galois, shifts right with taps 16'hB400.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0); ACE1 -> E270.
  - Advances every cycle in SHUF, and only in SHUF.
  - seed_load with seed != 0 overrides the advance that cycle (lfsr <= seed).
  - seed_load with seed == 0 is ignored.
- Lookup (IDLE only), 1-cycle latency:
  - If rqindex has exactly one bit k set with k < LEN, rowbias <= perm[k] on the next edge.
  - Otherwise (sentinel bit LEN set, zero bits, or more than one bit) rowbias <= 0.
  - This suits the tile sequence: rqindex is driven in the request cycle and rowbias is sampled in the following (load) cycle.
- States: IDLE, SHUF, DONE.
  - IDLE -> SHUF on updaterowbias=1. Load i <= LEN-1 and set busy <= 1.
    - A lookup in the same cycle is still served from the pre-shuffle permutation.
  - SHUF, every cycle: candidate j = lfsr[IW-1:0].
    - If j <= i: swap perm[i] and perm[j] (j == i leaves perm unchanged), then i <= i-1.
    - If j > i: reject; no swap and i unchanged.
    - On the cycle i == 1 is accepted, go to DONE.
  - DONE -> IDLE after one cycle. busy <= 0 on that edge.
- While busy=1:
  - rowbias is held at 0 and rqindex is ignored.
  - updaterowbias is ignored; there is no queuing.
  - A seed_load takes effect mid-shuffle and the shuffle continues with the new sequence.
- Shuffle duration: at least LEN-1 cycles in SHUF plus 1 in DONE; rejections add cycles. Termination is guaranteed because the LFSR has maximal period.
- Invariants:
  - perm is always a permutation of the one-hot values.
  - The OR of all entries is {LEN{1'b1}}.
  - Each entry is one-hot.
  - rowbias is always 0 or one-hot.

Test Plan:
1. Release reset, rqindex=10'b0000001000 -> rowbias=9'b000001000 on the next edge. Sweep k=0..8 -> rowbias=1<<k; busy=0 throughout.
2. rqindex=10'b1000000000 (sentinel), then 0, then 10'b0000000011 -> rowbias=0 each following cycle.
3. Pulse updaterowbias with LFSR=ACE1 -> busy=1 for at least 9 cycles, then 0; rowbias=0 while busy. Afterwards read k=0..8:
   - each result is one-hot and their OR is 9'h1FF;
   - the order matches a bench Galois/Fisher-Yates model exactly.
4. seed_load with seed=16'h1234, shuffle, read all entries; reset, load 1234 again, shuffle -> identical permutation. seed_load with seed=0 -> LFSR unchanged (the next shuffle matches the model with no seed loaded).
5. Pulse updaterowbias again 3 cycles into a shuffle -> ignored (a single shuffle, model-matched). Assert reset mid-shuffle -> within the same cycle busy=0, rowbias=0, perm is identity.
6. updaterowbias together with rqindex=1<<2 -> rowbias=9'b000000100 (pre-shuffle value) on the next edge, then 0 while busy.
